cdc_handshake_tx: RTL and testbench

- Source-domain half of a req/ack toggle handshake that moves multi-bit words between clock domains.
- Captures a word from a valid/ready producer and holds it stable on xfer_data.
- Flips req_tgl, then blocks until the destination's ack_tgl, resynchronised locally through SYNC_STAGES flops, matches req_tgl.
- Pairs with the destination-side 2-flop synchroniser/capture block. All logic runs in the source clock domain.

---
 rtl/cdc_handshake_tx.sv | 108 ++++++++++
 tb/tb_cdc_handshake_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source-domain half of a req/ack toggle handshake: captures one word, flips req_tgl,
// and holds the word until the resynchronised ack_tgl catches up with req_tgl.
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] xfer_data,
  output logic             req_tgl,
  input  logic             ack_tgl,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count,
  output logic             proto_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   ack_prev;

  logic                   req_nxt;
  logic [WIDTH-1:0]       data_nxt;
  logic                   ready_nxt;
  logic                   busy_nxt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   err_nxt;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Synchroniser stage: ack_tgl is asynchronous, used nowhere but here
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
      ack_prev <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
      ack_prev <= ack_s;
    end
  end

  // Control stage: every output is launched from a flop, never from in_data directly
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_tgl    <= 1'b0;
      xfer_data  <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      xfer_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_tgl    <= req_nxt;
      xfer_data  <= data_nxt;
      in_ready   <= ready_nxt;
      busy       <= busy_nxt;
      xfer_count <= cnt_nxt;
      proto_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_tgl;
    data_nxt  = xfer_data;
    ready_nxt = in_ready;
    busy_nxt  = busy;
    cnt_nxt   = xfer_count;
    err_nxt   = proto_err;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          data_nxt  = in_data;
          req_nxt   = ~req_tgl;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = WAIT_ACK;
        end
        // An ack edge that does not answer our request is flagged and otherwise ignored
        if ((ack_s != ack_prev) && (ack_s != req_tgl)) begin
          err_nxt = 1'b1;
        end
      end
      WAIT_ACK: begin
        ready_nxt = 1'b0;
        if (ack_s == req_tgl) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
          cnt_nxt   = xfer_count + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: a per-edge vector table for reset and the first
// transfer, then hand-written sequences for hold, streaming, spurious ack, wrap and reset.
module tb_cdc_handshake_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] xfer_data;
  logic       req_tgl;
  logic       ack_tgl;
  logic       busy;
  logic [3:0] xfer_count;
  logic       proto_err;

  int n_cmp;
  int n_err;

  logic       m_req;
  logic [3:0] m_cnt;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       ack;
    logic       rdy;
    logic       busy;
    logic       req;
    logic [7:0] xd;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[12];

  cdc_handshake_tx #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .xfer_data(xfer_data),
    .req_tgl(req_tgl),
    .ack_tgl(ack_tgl),
    .busy(busy),
    .xfer_count(xfer_count),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    ack_tgl = 1'b0;
    repeat (3) begin
      tick();
      check("rst_rdy", in_ready, 0);
      check("rst_req", req_tgl, 0);
      check("rst_cnt", xfer_count, 0);
    end
    rst = 1'b0;
    tick();
    check("rel_rdy", in_ready, 1);
    check("rel_err", proto_err, 0);
    m_req = 1'b0;
    m_cnt = 4'd0;
  endtask

  // Accept one word, model destination acks 3 edges after the req toggle
  task automatic xfer(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    m_req = ~m_req;
    check("acc_req", req_tgl, m_req);
    check("acc_data", xfer_data, d);
    check("acc_busy", busy, 1);
    check("acc_rdy", in_ready, 0);
    in_valid = 1'b0;
    in_data = ~d;
    repeat (3) begin
      tick();
      check("hold_data", xfer_data, d);
      check("hold_busy", busy, 1);
    end
    ack_tgl = m_req;
    repeat (2) begin
      tick();
      check("wait_rdy", in_ready, 0);
    end
    tick();
    m_cnt = m_cnt + 4'd1;
    check("done_rdy", in_ready, 1);
    check("done_busy", busy, 0);
    check("done_cnt", xfer_count, m_cnt);
    check("done_req", req_tgl, m_req);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    ack_tgl = 1'b0;
    m_req = 1'b0;
    m_cnt = 4'd0;

    //           rst   vld   data   ack   rdy   busy  req   xd     cnt
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 4'd1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 4'd1};

    // Row k is driven before edge k+1 and checked just after it
    for (int k = 0; k < 12; k++) begin
      rst = tbl[k].rst;
      in_valid = tbl[k].vld;
      in_data = tbl[k].data;
      ack_tgl = tbl[k].ack;
      tick();
      check("tv_rdy", in_ready, tbl[k].rdy);
      check("tv_busy", busy, tbl[k].busy);
      check("tv_req", req_tgl, tbl[k].req);
      check("tv_xd", xfer_data, tbl[k].xd);
      check("tv_cnt", xfer_count, tbl[k].cnt);
      check("tv_err", proto_err, 0);
    end
    m_req = 1'b1;
    m_cnt = 4'd1;

    // Hold stability: in_data sweeps every value with in_valid high while waiting
    in_valid = 1'b1;
    in_data = 8'hC3;
    tick();
    m_req = 1'b0;
    check("hs_acc_req", req_tgl, m_req);
    check("hs_acc_xd", xfer_data, 8'hC3);
    for (int i = 0; i < 256; i++) begin
      in_data = i[7:0];
      tick();
      check("hs_xd", xfer_data, 8'hC3);
      check("hs_req", req_tgl, 0);
      check("hs_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    ack_tgl = 1'b0;
    repeat (2) begin
      tick();
      check("hs_wait_busy", busy, 1);
    end
    tick();
    check("hs_done_rdy", in_ready, 1);
    check("hs_done_cnt", xfer_count, 2);

    // Stream of four words
    do_reset();
    xfer(8'h11);
    check("st_req1", req_tgl, 1);
    xfer(8'h22);
    check("st_req2", req_tgl, 0);
    xfer(8'h33);
    check("st_req3", req_tgl, 1);
    xfer(8'h44);
    check("st_req4", req_tgl, 0);
    check("st_cnt", xfer_count, 4);
    check("st_err", proto_err, 0);

    // Spurious ack pulse while idle with req_tgl = 0
    ack_tgl = 1'b1;
    tick();
    ack_tgl = 1'b0;
    tick();
    check("sp_err_early", proto_err, 0);
    check("sp_rdy1", in_ready, 1);
    tick();
    check("sp_err", proto_err, 1);
    check("sp_rdy2", in_ready, 1);
    check("sp_busy", busy, 0);
    check("sp_cnt", xfer_count, 4);
    xfer(8'h77);
    check("sp_after_cnt", xfer_count, 5);
    check("sp_sticky", proto_err, 1);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int n = 0; n < 17; n++) begin
      xfer(8'(n * 13 + 1));
    end
    check("wrap_cnt", xfer_count, 1);

    // Source reset mid-transfer
    in_valid = 1'b1;
    in_data = 8'h9E;
    tick();
    check("rm_busy", busy, 1);
    check("rm_xd", xfer_data, 8'h9E);
    in_valid = 1'b0;
    rst = 1'b1;
    ack_tgl = 1'b0;
    tick();
    check("rm_req", req_tgl, 0);
    check("rm_busy0", busy, 0);
    check("rm_xd0", xfer_data, 0);
    check("rm_rdy", in_ready, 0);
    check("rm_cnt", xfer_count, 0);
    rst = 1'b0;
    tick();
    check("rm_rel_rdy", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
